// File: rtl/register_bank_param_pkg.sv
// Shared definitions for the parametrised register bank.
//   clr_state_e   : clear engine states (IDLE -> CLEAR -> CLR_W -> IDLE)
//   W_SEL_DEFAULT : select code for the working register W. The control-unit
//                   opcode decoder uses the same constant.
//   idx_width()   : width of a counter that walks NUM_REGS registers
package register_bank_param_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_CLR_W = 2'd2
  } clr_state_e;

  localparam int W_SEL_DEFAULT = 34;

  // Never return zero, so a one-register bank still gets a legal 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regbank_clear_fsm.sv
// Clear engine for the register bank.
// A clr_req pulse in IDLE starts the engine. It then zeroes one GPR per cycle
// from index 0 to NUM_REGS-1, and zeroes W in a final cycle.
// Ports:
//   clk, reset  : clock and asynchronous active-high reset
//   clr_req     : single-cycle start pulse. It is ignored while the engine runs.
//   clr_busy    : high while the engine is in CLEAR or CLR_W (NUM_REGS+1 cycles)
//   clr_idx     : GPR index that is cleared this cycle
//   clr_gpr_en  : zero GPR[clr_idx] at the next edge
//   clr_w_en    : zero W at the next edge
module regbank_clear_fsm
  import register_bank_param_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int IDX_W    = idx_width(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic [IDX_W-1:0] clr_idx,
  output logic             clr_gpr_en,
  output logic             clr_w_en
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  clr_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_gpr_en = 1'b0;
    clr_w_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clr_req) begin
          state_d = ST_CLEAR;
          idx_d   = '0;
        end
      end
      ST_CLEAR: begin
        clr_gpr_en = 1'b1;
        // The counter stops at the last GPR and never wraps.
        if (idx_q == LAST_IDX) begin
          state_d = ST_CLR_W;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CLR_W: begin
        clr_w_en = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign clr_busy = (state_q != ST_IDLE);
  assign clr_idx  = idx_q;

endmodule

// File: rtl/register_bank_param.sv
// Parametrised general-purpose register bank.
// The bank holds NUM_REGS GPRs plus a working register W. It has two
// registered read ports, A and B, and one write port on bus C. W can also be
// loaded from memory. A clear engine zeroes the whole bank when requested.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   sel_a           : port A select. Only GPRs can be read; any other code reads 0.
//   sel_b           : port B select. GPRs or W_SEL; any other code reads 0.
//   sel_c, data_c   : write select and write data from bus C
//   wr_en           : write strobe
//   mr, w_in        : memory load of W. It wins over a bus-C write to W.
//   clr_req         : start pulse for the clear engine
//   clr_busy        : high while the clear engine runs. Writes and loads are
//                     ignored during this time.
//   data_a, data_b  : registered read data, 1-cycle latency, write-first bypass
//   w_out           : current W value
module register_bank_param
  import register_bank_param_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 32,
  parameter int SEL_W    = 6,
  parameter int W_SEL    = W_SEL_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  sel_a,
  input  logic [SEL_W-1:0]  sel_b,
  input  logic [SEL_W-1:0]  sel_c,
  input  logic [DATA_W-1:0] data_c,
  input  logic              wr_en,
  input  logic              mr,
  input  logic [DATA_W-1:0] w_in,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic [DATA_W-1:0] data_a,
  output logic [DATA_W-1:0] data_b,
  output logic [DATA_W-1:0] w_out
);

  localparam int               IDX_W      = idx_width(NUM_REGS);
  localparam logic [SEL_W-1:0] NUM_REGS_S = SEL_W'(NUM_REGS);
  localparam logic [SEL_W-1:0] W_SEL_S    = SEL_W'(W_SEL);

  logic [DATA_W-1:0] gpr_q [NUM_REGS];
  logic [DATA_W-1:0] gpr_d [NUM_REGS];
  logic [DATA_W-1:0] w_q, w_d;
  logic [DATA_W-1:0] data_a_q, data_a_d;
  logic [DATA_W-1:0] data_b_q, data_b_d;

  logic             clr_gpr_en;
  logic             clr_w_en;
  logic [IDX_W-1:0] clr_idx;

  logic wr_ok, mr_ok, wr_gpr, wr_w;

  regbank_clear_fsm #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_clear_fsm (
    .clk        (clk),
    .reset      (reset),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_idx    (clr_idx),
    .clr_gpr_en (clr_gpr_en),
    .clr_w_en   (clr_w_en)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= '0;
      end
      w_q      <= '0;
      data_a_q <= '0;
      data_b_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_q[i] <= gpr_d[i];
      end
      w_q      <= w_d;
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  always_comb begin
    // Bus-C writes and memory loads are blocked while the clear engine runs.
    wr_ok  = wr_en && !clr_busy;
    mr_ok  = mr && !clr_busy;
    wr_gpr = wr_ok && (sel_c < NUM_REGS_S);
    wr_w   = wr_ok && (sel_c == W_SEL_S);

    for (int i = 0; i < NUM_REGS; i++) begin
      gpr_d[i] = gpr_q[i];
    end
    if (wr_gpr) begin
      gpr_d[sel_c[IDX_W-1:0]] = data_c;
    end
    if (clr_gpr_en) begin
      gpr_d[clr_idx] = '0;
    end

    w_d = w_q;
    if (mr_ok) begin
      w_d = w_in;
    end else if (wr_w) begin
      w_d = data_c;
    end
    if (clr_w_en) begin
      w_d = '0;
    end

    // Read ports are write-first. A write or load that takes effect at this
    // edge is forwarded to the port instead of the old contents. Clearing is
    // not forwarded, so a read during the clear returns the value before the
    // clear.
    data_a_d = '0;
    if (sel_a < NUM_REGS_S) begin
      data_a_d = (wr_gpr && (sel_c == sel_a)) ? data_c : gpr_q[sel_a[IDX_W-1:0]];
    end

    data_b_d = '0;
    if (sel_b < NUM_REGS_S) begin
      data_b_d = (wr_gpr && (sel_c == sel_b)) ? data_c : gpr_q[sel_b[IDX_W-1:0]];
    end else if (sel_b == W_SEL_S) begin
      if (mr_ok) begin
        data_b_d = w_in;
      end else if (wr_w) begin
        data_b_d = data_c;
      end else begin
        data_b_d = w_q;
      end
    end
  end

  assign data_a = data_a_q;
  assign data_b = data_b_q;
  assign w_out  = w_q;

endmodule

// File: tb/tb_register_bank_param.sv
// Testbench for register_bank_param. Expected outputs come from an array-based
// reference model. They are queued on each edge and checked by a monitor on
// the falling clock edge.
module tb_register_bank_param;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 32;
  localparam int SEL_W    = 6;
  localparam int W_SEL    = 34;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [SEL_W-1:0]  sel_a = '0, sel_b = '0, sel_c = '0;
  logic [DATA_W-1:0] data_c = '0, w_in = '0;
  logic              wr_en = 1'b0, mr = 1'b0, clr_req = 1'b0;
  logic              clr_busy;
  logic [DATA_W-1:0] data_a, data_b, w_out;

  register_bank_param #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .SEL_W    (SEL_W),
    .W_SEL    (W_SEL)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sel_a    (sel_a),
    .sel_b    (sel_b),
    .sel_c    (sel_c),
    .data_c   (data_c),
    .wr_en    (wr_en),
    .mr       (mr),
    .w_in     (w_in),
    .clr_req  (clr_req),
    .clr_busy (clr_busy),
    .data_a   (data_a),
    .data_b   (data_b),
    .w_out    (w_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] w;
    logic              busy;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state
  logic [DATA_W-1:0] m_regs [NUM_REGS];
  logic [DATA_W-1:0] m_w;
  int                m_rem;  // clear cycles still to run; 0 means idle

  task automatic check(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: at each falling edge, compare the response of the last rising edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("data_a", data_a, e.a);
      check("data_b", data_b, e.b);
      check("w_out", w_out, e.w);
      check("clr_busy", {15'd0, clr_busy}, {15'd0, e.busy});
    end
  end

  task automatic model_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
    m_w   = '0;
    m_rem = 0;
  endtask

  // Apply one cycle of stimulus. Predict the response, let the edge pass and
  // queue the prediction. Returns 1 time unit after the rising edge.
  task automatic cycle(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb,
                       input logic [SEL_W-1:0] sc, input logic [DATA_W-1:0] dc,
                       input logic we, input logic m, input logic [DATA_W-1:0] wi,
                       input logic cr);
    exp_t e;
    bit   busy, wr_ok, mr_ok;
    int   a, b, c;
    sel_a = sa; sel_b = sb; sel_c = sc; data_c = dc;
    wr_en = we; mr = m; w_in = wi; clr_req = cr;
    a = int'(sa); b = int'(sb); c = int'(sc);
    busy  = (m_rem > 0);
    wr_ok = we && !busy;
    mr_ok = m && !busy;

    e.a = '0;
    if (a < NUM_REGS) e.a = (wr_ok && c == a) ? dc : m_regs[a];
    e.b = '0;
    if (b < NUM_REGS) e.b = (wr_ok && c == b) ? dc : m_regs[b];
    else if (b == W_SEL) e.b = mr_ok ? wi : ((wr_ok && c == W_SEL) ? dc : m_w);

    if (wr_ok && c < NUM_REGS) m_regs[c] = dc;
    if (mr_ok) m_w = wi;
    else if (wr_ok && c == W_SEL) m_w = dc;

    if (busy) begin
      int step;
      step = NUM_REGS + 1 - m_rem;
      if (step < NUM_REGS) m_regs[step] = '0;
      else m_w = '0;
      m_rem--;
    end else if (cr) begin
      m_rem = NUM_REGS + 1;
    end

    e.w    = m_w;
    e.busy = (m_rem > 0);
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle_read(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sb);
    cycle(sa, sb, 6'd63, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Assert reset between edges. Outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    wr_en = 1'b0; mr = 1'b0; clr_req = 1'b0;
    #1;
    check("rst data_a", data_a, '0);
    check("rst data_b", data_b, '0);
    check("rst w_out", w_out, '0);
    check("rst clr_busy", {15'd0, clr_busy}, 16'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic fill_all();
    for (int r = 0; r < NUM_REGS; r++)
      cycle(6'(r), 6'(W_SEL), 6'(r), DATA_W'($urandom) | 16'h0001, 1'b1, 1'b0, '0, 1'b0);
    cycle('0, 6'(W_SEL), 6'(W_SEL), 16'hA5A5, 1'b1, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_busy;
    model_reset();
    do_reset();

    // Every select code reads zero after reset
    for (int s = 0; s < 64; s++) idle_read(6'(s), 6'(s));

    // Plain write, then read back, then write-first bypass
    cycle('0, '0, 6'd5, 16'h1234, 1'b1, 1'b0, '0, 1'b0);
    idle_read(6'd5, 6'd5);
    check("r5 readback", data_a, 16'h1234);
    cycle(6'd5, 6'd5, 6'd5, 16'hBEEF, 1'b1, 1'b0, '0, 1'b0);
    check("r5 bypass", data_a, 16'hBEEF);

    // W write, then a write to an unused code leaves everything alone
    cycle('0, 6'(W_SEL), 6'(W_SEL), 16'h00AA, 1'b1, 1'b0, '0, 1'b0);
    check("w write", w_out, 16'h00AA);
    cycle('0, 6'(W_SEL), 6'd35, 16'h0000, 1'b1, 1'b0, '0, 1'b0);
    check("w after sel 35", w_out, 16'h00AA);
    for (int r = 0; r < NUM_REGS; r++) idle_read(6'(r), 6'(W_SEL));

    // Memory load wins over a bus-C write to W, including on port B
    cycle('0, 6'(W_SEL), 6'(W_SEL), 16'h1111, 1'b1, 1'b1, 16'h5555, 1'b0);
    check("mr priority w", w_out, 16'h5555);
    check("mr bypass b", data_b, 16'h5555);

    // Full clear with an ignored write and load while busy
    fill_all();
    n_busy = 0;
    for (int i = 0; i < 60; i++) begin
      if (i == 0) cycle('0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
      else if (i == 5) cycle(6'd3, 6'(W_SEL), 6'd3, 16'h7777, 1'b1, 1'b1, 16'h6666, 1'b1);
      else idle_read(6'($urandom_range(0, 31)), 6'(W_SEL));
      if (clr_busy) n_busy++;
      else break;
    end
    check("busy cycles", 16'(n_busy), 16'(NUM_REGS + 1));
    check("w after clear", w_out, '0);
    for (int r = 0; r < NUM_REGS; r++) idle_read(6'(r), 6'(r));

    // Reset in the middle of a clear, then a new clear runs from index 0
    fill_all();
    cycle('0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) idle_read(6'(i), 6'(i + 16));
    do_reset();
    fill_all();
    cycle('0, '0, '0, '0, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < NUM_REGS + 3; i++) idle_read(6'(NUM_REGS - 1 - (i % NUM_REGS)), 6'(W_SEL));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic [SEL_W-1:0] sa, sb, sc;
      sa = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31));
      sb = ($urandom_range(0, 3) == 0) ? 6'(W_SEL) : 6'($urandom_range(0, 63));
      sc = ($urandom_range(0, 3) == 0) ? 6'(W_SEL) : 6'($urandom_range(0, 63));
      cycle(sa, sb, sc, DATA_W'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0), DATA_W'($urandom), ($urandom_range(0, 60) == 0));
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_bank_param.md
Name: register_bank_param

Overview:
- Parametrised successor of the CPU's general-purpose register bank in the datapath between the A/B operand buses and the ALU result bus C.
- Provides N GPRs, a dedicated working register W and a memory-load path into W.
- Adds an explicit write enable, write-to-read bypass and a multi-cycle hardware clear engine.
- Out-of-range selects are defined and can never corrupt W.

Parameters:
- DATA_W, 16, register and bus width
- NUM_REGS, 32, number of GPRs (r0..r{NUM_REGS-1}); must be <= 2**SEL_W - 1
- SEL_W, 6, width of all select buses
- W_SEL, 34, select code addressing W on port B and port C; must be >= NUM_REGS

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- sel_a  in  SEL_W  port A read select (GPRs only)
- sel_b  in  SEL_W  port B read select (GPRs or W_SEL)
- sel_c  in  SEL_W  write select (GPRs or W_SEL)
- data_c  in  DATA_W  write data from bus C
- wr_en  in  1  write strobe for sel_c/data_c
- mr  in  1  memory read: load W from w_in
- w_in  in  DATA_W  memory data into W
- clr_req  in  1  single-cycle pulse, starts clear of all registers
- clr_busy  out  1  high while clear engine runs
- data_a  out  DATA_W  registered port A data
- data_b  out  DATA_W  registered port B data
- w_out  out  DATA_W  current W value

Behaviour:
- Reset (async, any time incl. mid-clear): all GPRs, W, data_a, data_b, w_out = 0; clr_busy = 0; FSM = IDLE.
- Reads are registered with 1-cycle latency. data_a/data_b update on every clk edge from the selects sampled at that edge.
- Port A: sel_a < NUM_REGS returns that GPR; any other code returns 0.
- Port B: sel_b < NUM_REGS returns that GPR; sel_b == W_SEL returns W; any other code returns 0.
- Write-first bypass:
  - If wr_en and sel_c matches the read select in the same cycle, the read port captures data_c, not the old value.
  - Applies to the W_SEL match on port B as well.
  - If mr loads W in the same cycle, port B at W_SEL captures w_in.
- Writes:
  - Only when wr_en = 1 and FSM = IDLE.
  - sel_c < NUM_REGS writes that GPR.
  - sel_c == W_SEL writes W.
  - Any other code is a no-op; W is never written by default.
- mr = 1 loads W from w_in. mr has priority over a simultaneous wr_en to W_SEL. A simultaneous GPR write still completes.
- w_out is W directly (no extra latency beyond W's register).
- Clear FSM: IDLE -> CLEAR -> CLR_W -> IDLE.
  - IDLE: clr_req = 1 -> CLEAR with idx = 0; clr_busy = 1 from the next cycle.
  - CLEAR: zero GPR[idx] each cycle. idx == NUM_REGS-1 -> CLR_W.
  - CLR_W: zero W -> IDLE; clr_busy drops the following cycle.
  - Total busy = NUM_REGS + 1 cycles.
  - While busy: wr_en and mr are ignored; clr_req is ignored; reads continue and return current (partially cleared) contents.
- idx counter width = clog2(NUM_REGS). No wrap beyond NUM_REGS-1.

Decomposition:
- Shared package: FSM state enum (IDLE, CLEAR, CLR_W) and the default W_SEL code constant, also used by the control-unit opcode decoder.
- One natural sub-module: regbank_clear_fsm (FSM + idx counter, outputs clr_busy, clr_idx, clr_gpr_en, clr_w_en).
- Storage, bypass and read muxes stay in the top.

Test Plan:
- Reset then read all selects -> data_a = data_b = w_out = 0 one cycle after each select.
- Write r5 = 0x1234 (wr_en, sel_c = 5), next cycle sel_a = 5 -> data_a = 0x1234. Same-cycle sel_a = 5 with write 0xBEEF -> data_a = 0xBEEF (bypass).
- wr_en, sel_c = W_SEL, data_c = 0x00AA -> w_out = 0x00AA. Then wr_en, sel_c = 35, data_c = 0 -> w_out stays 0x00AA, no GPR changed.
- mr = 1, w_in = 0x5555 together with wr_en, sel_c = W_SEL, data_c = 0x1111 -> w_out = 0x5555. Port B at W_SEL same cycle -> 0x5555.
- Fill all regs and W with nonzero, pulse clr_req -> clr_busy high exactly 33 cycles. A wr_en to r3 during busy is ignored. Afterwards all GPRs and W = 0.
- Assert reset at clear cycle 10 -> all outputs 0 immediately, clr_busy = 0. New clr_req after release restarts from idx 0.
